seq_shift_add_mult5: RTL and testbench

//  Sequential 5x5 unsigned shift-and-add multiplier; feeds operands to the team's

---
 rtl/mult_pkg.sv | 16 +
 rtl/fiveBitFullAdder.sv | 22 ++
 rtl/seq_shift_add_mult5.sv | 98 +++++++++
 tb/tb_seq_shift_add_mult5.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier and its adder.
package mult_pkg;

  // Operand width; fixed by the five-bit adder datapath.
  localparam int MULT_WIDTH = 5;

  // Iteration-counter width, ceil(log2(MULT_WIDTH+1)).
  localparam int MULT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fiveBitFullAdder.sv
// Combinational five-bit ripple-carry adder used as the multiplier's arithmetic unit.
module fiveBitFullAdder (
  input  logic [4:0] A,
  input  logic [4:0] B,
  input  logic       Cin,
  output logic [4:0] Sum,
  output logic       Cout
);

  logic [5:0] carry;

  assign carry[0] = Cin;

  // One full-adder cell per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < 5; i++) begin : g_bit
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
  end

  assign Cout = carry[5];

endmodule

// File: rtl/seq_shift_add_mult5.sv
// Sequential 5x5 unsigned shift-and-add multiplier with a registered 10-bit product.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one add-and-shift per clock, WIDTH iterations
// DONE  | product valid, done pulsed for this single cycle
module seq_shift_add_mult5
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   p_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] pq_next;
  logic               last_iter;

  // Multiplicand is added only when the current multiplier LSB is set.
  assign addend = q_reg[0] ? m_reg : '0;

  fiveBitFullAdder u_adder (
    .A    (p_reg),
    .B    (addend),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  // {Cout, Sum, Q} shifted right by one; the carry lands in the product MSB so
  // the partial product never loses a bit.
  assign pq_next   = {cout, sum, q_reg[WIDTH-1:1]};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Control FSM, datapath registers and registered outputs in one process.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m_reg   <= '0;
      p_reg   <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= a;
            q_reg <= b;
            p_reg <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          {p_reg, q_reg} <= pq_next;
          cnt            <= cnt + CNT_W'(1);
          if (last_iter) begin
            product <= pq_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here; a new request needs IDLE.
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult5.sv
// Directed and random self-checking bench for seq_shift_add_mult5.
module tb_seq_shift_add_mult5;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] a;
  logic [4:0] b;
  logic [9:0] product;
  logic       busy;
  logic       done;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[7];

  seq_shift_add_mult5 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Single start pulse, then wait (bounded) for done and check latency/product/pulse width.
  task automatic run_op(input logic [4:0] va, input logic [4:0] vb, input logic [9:0] exp,
                        input string name);
    int k;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~va; b = ~vb;
    chk({name, " busy_after_accept"}, busy, 1);
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (done) break;
    end
    chk({name, " latency"}, k, 5);
    chk({name, " product"}, product, exp);
    chk({name, " busy_at_done"}, busy, 0);
    @(posedge clk); #1;
    chk({name, " done_width"}, done, 0);
  endtask

  initial begin
    bit seen;
    logic [4:0] ra, rb;
    n_vec = 0;
    n_bad = 0;

    vecs[0] = '{5'd21, 5'd13, 10'd273};
    vecs[1] = '{5'd31, 5'd31, 10'd961};
    vecs[2] = '{5'd0,  5'd31, 10'd0};
    vecs[3] = '{5'd31, 5'd0,  10'd0};
    vecs[4] = '{5'd1,  5'd1,  10'd1};
    vecs[5] = '{5'd17, 5'd3,  10'd51};
    vecs[6] = '{5'd16, 5'd30, 10'd480};

    // Reset with start held high: nothing may start.
    rst = 1'b1; start = 1'b1; a = 5'd7; b = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("rst product", product, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("post_rst busy", busy, 0);
    chk("post_rst done", done, 0);

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // start held continuously; operands changed during RUN.
    @(negedge clk);
    a = 5'd3; b = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    a = 5'd31; b = 5'd31;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k <= 4) chk($sformatf("held busy k%0d", k), busy, 1);
      if (k == 5) begin
        chk("held done k5", done, 1);
        chk("held product k5", product, 21);
        chk("held busy k5", busy, 0);
      end
      if (k == 6) begin
        chk("held done k6", done, 0);
        chk("held busy k6", busy, 0);
      end
      if (k == 7) begin
        chk("held reaccept busy k7", busy, 1);
        chk("held product kept k7", product, 21);
      end
    end
    @(negedge clk);
    start = 1'b0; a = 5'd0; b = 5'd0;
    seen = 1'b0;
    for (int k = 8; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        chk("held second latency", k, 12);
        chk("held second product", product, 961);
      end
    end
    chk("held second done seen", seen, 1);
    @(posedge clk); #1;

    // Reset in the third RUN cycle aborts the operation.
    @(negedge clk);
    a = 5'd25; b = 5'd19; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort product", product, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort no_activity", seen, 0);

    // Random operand pairs against a*b.
    for (int i = 0; i < 200; i++) begin
      ra = 5'($urandom_range(31, 0));
      rb = 5'($urandom_range(31, 0));
      run_op(ra, rb, 10'(ra * rb), $sformatf("rnd%0d(%0d*%0d)", i, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
